debounce_multi: RTL

//   N-channel push-button conditioner for the board front panel: 2-flop input

---
 rtl/debounce_multi_if.sv | 24 ++
 rtl/debounce_multi.sv | 124 ++++++++++++
 2 files changed

// File: rtl/debounce_multi_if.sv
// Front-panel button bundle: raw pins in, conditioned levels and strobes out.
interface debounce_multi_if #(
  parameter int N = 4
) ();

  logic [N-1:0] button;
  logic [N-1:0] button_out;
  logic [N-1:0] press;
  logic [N-1:0] release_pulse;
  logic [N-1:0] btn_long;
  logic [N-1:0] long_pulse;
  logic         tick;

  modport master (
    output button,
    input  button_out, press, release_pulse, btn_long, long_pulse, tick
  );

  modport slave (
    input  button,
    output button_out, press, release_pulse, btn_long, long_pulse, tick
  );

endinterface

// File: rtl/debounce_multi.sv
// N-channel push-button conditioner: input sync, shared tick prescaler,
// per-channel stability debounce, press/release strobes and long-press detect.
module debounce_multi #(
  parameter int N          = 4,
  parameter int TICK_DIV   = 25000,
  parameter int STABLE_CNT = 15,
  parameter int LONG_TICKS = 1000
) (
  input logic           clk,
  input logic           rst,
  debounce_multi_if.slave bus
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W  = $clog2(STABLE_CNT + 1);
  localparam int HOLD_W = $clog2(LONG_TICKS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CNT);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);

  logic [N-1:0]      s1;
  logic [N-1:0]      s2;
  logic [N-1:0]      cand;
  logic [N-1:0]      level;
  logic [N-1:0]      level_q;
  logic [N-1:0]      long_lvl;
  logic [N-1:0]      long_q;
  logic [CNT_W-1:0]  cnt  [N];
  logic [HOLD_W-1:0] hold [N];
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  div_next;
  logic              tick_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.button;
      s2 <= s1;
    end
  end

  always_comb begin
    div_next = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
  end

  // tick is registered so it is exactly "div == TICK_DIV-1" yet stays low in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div    <= '0;
      tick_r <= 1'b0;
    end else begin
      div    <= div_next;
      tick_r <= (div_next == DIV_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand  <= '0;
      level <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else if (tick_r) begin
      for (int i = 0; i < N; i++) begin
        if (s2[i] != cand[i]) begin
          cand[i] <= s2[i];
          cnt[i]  <= '0;
        end else if (cnt[i] < CNT_MAX) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
          if ((cnt[i] + CNT_W'(1) == CNT_MAX) && (cand[i] != level[i])) begin
            level[i] <= cand[i];
          end
        end
      end
    end
  end

  // Hold time only accumulates while the debounced level is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!level[i]) begin
          hold[i] <= '0;
        end else if (tick_r && (hold[i] < HOLD_MAX)) begin
          hold[i] <= hold[i] + HOLD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      long_q  <= '0;
    end else begin
      level_q <= level;
      long_q  <= long_lvl;
    end
  end

  // Gating with level makes btn_long fall on the same cycle as button_out
  always_comb begin
    long_lvl = '0;
    for (int i = 0; i < N; i++) begin
      long_lvl[i] = level[i] && (hold[i] == HOLD_MAX);
    end
  end

  assign bus.button_out    = level;
  assign bus.press         = level & ~level_q;
  assign bus.release_pulse = ~level & level_q;
  assign bus.btn_long      = long_lvl;
  assign bus.long_pulse    = long_lvl & ~long_q;
  assign bus.tick          = tick_r;

endmodule
